// File: rtl/scb_pkg.sv
// -----------------------------------------------------------------------------
// scb_pkg
//   Shared types and constants for the commit scoreboard.
//   - state_e    : scoreboard run state (IDLE, RUN, DONE, FAIL)
//   - err_kind_e : first-error classification reported on err_kind_o
//   - COUNT_W    : width of the compare counters and error index
//   - sat_inc()  : saturating increment for COUNT_W-wide counters
// -----------------------------------------------------------------------------
package scb_pkg;

  localparam int COUNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_PC       = 3'd1,
    ERR_DEST     = 3'd2,
    ERR_DATA     = 3'd3,
    ERR_OVERFLOW = 3'd4,
    ERR_TIMEOUT  = 3'd5
  } err_kind_e;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

endpackage

// File: rtl/scb_fifo.sv
// -----------------------------------------------------------------------------
// scb_fifo
//   Synchronous FIFO holding commit records for the scoreboard.
//   Ports:
//     clk_i, rst_i   clock, asynchronous active-high reset
//     push_i         write data_i this edge (dropped if full and not popping)
//     pop_i          discard the head entry this edge (ignored when empty)
//     flush_i        empty the FIFO this edge; overrides push/pop
//     data_i         record to write
//     full_o/empty_o occupancy flags
//     head_o         oldest entry (valid when !empty_o)
//   Pointers carry one wrap bit above the index so full and empty are
//   distinguishable when the indices coincide.
// -----------------------------------------------------------------------------
module scb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // When full, a simultaneous pop frees the slot being written.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign head_o = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/commit_scoreboard.sv
// -----------------------------------------------------------------------------
// commit_scoreboard
//   In-order commit checker: buffers instructions retired by the CPU and a
//   golden-model record stream in two FIFOs, compares the heads pairwise,
//   counts matches/mismatches, latches the first error and flags overflow
//   of the DUT FIFO and stalls (timeout).
//   Ports:
//     clk_i, rst_i        clock, asynchronous active-high reset
//     start_i             begin a run from IDLE/DONE/FAIL (ignored in RUN)
//     dut_*_i             DUT commit record, strobed by dut_valid_i
//     ref_*_i, ref_ready_o golden record with valid/ready handshake
//     busy_o              state is RUN
//     done_o              state is DONE or FAIL
//     pass_o              DONE with no mismatches
//     err_kind_o          first error class (scb_pkg::err_kind_e)
//     err_index_o         0-based compare index of the first error
//     match_cnt_o         matching compares (saturating)
//     err_cnt_o           mismatching compares (saturating)
// -----------------------------------------------------------------------------
module commit_scoreboard
  import scb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int REG_W       = 5,
  parameter int DEPTH       = 8,
  parameter int END_COUNT   = 25,
  parameter int TIMEOUT     = 64,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               dut_valid_i,
  input  logic [ADDR_W-1:0]  dut_pc_i,
  input  logic               dut_we_i,
  input  logic [REG_W-1:0]   dut_rd_i,
  input  logic [DATA_W-1:0]  dut_wdata_i,
  input  logic               ref_valid_i,
  output logic               ref_ready_o,
  input  logic [ADDR_W-1:0]  ref_pc_i,
  input  logic               ref_we_i,
  input  logic [REG_W-1:0]   ref_rd_i,
  input  logic [DATA_W-1:0]  ref_wdata_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [2:0]         err_kind_o,
  output logic [COUNT_W-1:0] err_index_o,
  output logic [COUNT_W-1:0] match_cnt_o,
  output logic [COUNT_W-1:0] err_cnt_o
);

  localparam int REC_W = ADDR_W + 1 + REG_W + DATA_W;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              we;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] wdata;
  } rec_t;

  state_e             state_q, state_d;
  err_kind_e          kind_q, kind_d, cmp_kind;
  logic [COUNT_W-1:0] match_q, match_d;
  logic [COUNT_W-1:0] err_q, err_d;
  logic [COUNT_W-1:0] idx_q, idx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               busy_q, done_q, pass_q;

  rec_t dut_in, ref_in, dut_head, ref_head;
  logic dut_full, dut_empty, ref_full, ref_empty;
  logic in_run, flush, dut_push, ref_push, compare, overflow;
  logic [COUNT_W:0]   total;
  logic [COUNT_W-1:0] total_idx;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  assign in_run      = (state_q == ST_RUN);
  assign flush       = start_i && !in_run;
  assign ref_ready_o = in_run && !ref_full;
  assign dut_push    = in_run && dut_valid_i;
  assign ref_push    = ref_valid_i && ref_ready_o;
  assign compare     = in_run && !dut_empty && !ref_empty;
  // A pop on the same edge makes room, so only an unmatched push overflows.
  assign overflow    = dut_push && dut_full && !compare;

  assign dut_in = '{pc: dut_pc_i, we: dut_we_i, rd: dut_rd_i, wdata: dut_wdata_i};
  assign ref_in = '{pc: ref_pc_i, we: ref_we_i, rd: ref_rd_i, wdata: ref_wdata_i};

  scb_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_dut_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (dut_push),
    .pop_i   (compare),
    .flush_i (flush),
    .data_i  (dut_in),
    .full_o  (dut_full),
    .empty_o (dut_empty),
    .head_o  (dut_head)
  );

  scb_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_ref_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ref_push),
    .pop_i   (compare),
    .flush_i (flush),
    .data_i  (ref_in),
    .full_o  (ref_full),
    .empty_o (ref_empty),
    .head_o  (ref_head)
  );

  // ---------------------------------------------------------------------------
  // Head comparison: PC beats destination beats data. rd only matters when the
  // instruction writes, and writes to r0 carry don't-care data.
  // ---------------------------------------------------------------------------
  always_comb begin
    cmp_kind = ERR_NONE;
    if (dut_head.pc != ref_head.pc) begin
      cmp_kind = ERR_PC;
    end else if ((dut_head.we != ref_head.we) ||
                 (dut_head.we && (dut_head.rd != ref_head.rd))) begin
      cmp_kind = ERR_DEST;
    end else if (dut_head.we && (dut_head.rd != '0) &&
                 (dut_head.wdata != ref_head.wdata)) begin
      cmp_kind = ERR_DATA;
    end
  end

  // Compares completed so far; the index of the compare happening now.
  assign total     = {1'b0, match_q} + {1'b0, err_q};
  assign total_idx = total[COUNT_W] ? '1 : total[COUNT_W-1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    match_d = match_q;
    err_d   = err_q;
    idx_d   = idx_q;
    timer_d = timer_q;

    case (state_q)
      ST_RUN: begin
        if (compare) begin
          timer_d = '0;
          if (cmp_kind != ERR_NONE) begin
            err_d = sat_inc(err_q);
            if (kind_q == ERR_NONE) begin
              kind_d = cmp_kind;
              idx_d  = total_idx;
            end
            if (STOP_ON_ERR) state_d = ST_FAIL;
          end else begin
            match_d = sat_inc(match_q);
          end
          // A stopping mismatch on the final compare leaves FAIL in place.
          if ((int'(total) + 1 >= END_COUNT) && (state_d == ST_RUN)) begin
            state_d = ST_DONE;
          end
        end else if (overflow || (timer_q == TMR_W'(TIMEOUT - 1))) begin
          state_d = ST_FAIL;
          if (kind_q == ERR_NONE) begin
            kind_d = overflow ? ERR_OVERFLOW : ERR_TIMEOUT;
            idx_d  = total_idx;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        if (start_i) begin
          state_d = ST_RUN;
          kind_d  = ERR_NONE;
          match_d = '0;
          err_d   = '0;
          idx_d   = '0;
          timer_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      kind_q  <= ERR_NONE;
      match_q <= '0;
      err_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      match_q <= match_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
      busy_q  <= (state_d == ST_RUN);
      done_q  <= (state_d == ST_DONE) || (state_d == ST_FAIL);
      pass_q  <= (state_d == ST_DONE) && (err_d == '0);
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_kind_o  = kind_q;
  assign err_index_o = idx_q;
  assign match_cnt_o = match_q;
  assign err_cnt_o   = err_q;

endmodule

// File: tb/tb_commit_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_commit_scoreboard
//   Directed bench for commit_scoreboard. Two instances share all inputs:
//   u_stop (STOP_ON_ERR=1) and u_cont (STOP_ON_ERR=0). Expected values are
//   worked out by hand from the record tables built in each scenario.
// -----------------------------------------------------------------------------
module tb_commit_scoreboard;

  localparam int N = 25;

  typedef struct packed {
    logic [31:0] pc;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        dut_valid = 1'b0;
  logic        ref_valid = 1'b0;
  rec_t        dut_cur = '0;
  rec_t        ref_cur = '0;

  logic        s_ready, s_busy, s_done, s_pass;
  logic [2:0]  s_kind;
  logic [15:0] s_idx, s_match, s_err;
  logic        c_ready, c_busy, c_done, c_pass;
  logic [2:0]  c_kind;
  logic [15:0] c_idx, c_match, c_err;

  rec_t dut_r [N];
  rec_t ref_r [N];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  commit_scoreboard #(.STOP_ON_ERR(1'b1)) u_stop (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .dut_valid_i(dut_valid), .dut_pc_i(dut_cur.pc), .dut_we_i(dut_cur.we),
    .dut_rd_i(dut_cur.rd), .dut_wdata_i(dut_cur.wd),
    .ref_valid_i(ref_valid), .ref_ready_o(s_ready), .ref_pc_i(ref_cur.pc),
    .ref_we_i(ref_cur.we), .ref_rd_i(ref_cur.rd), .ref_wdata_i(ref_cur.wd),
    .busy_o(s_busy), .done_o(s_done), .pass_o(s_pass), .err_kind_o(s_kind),
    .err_index_o(s_idx), .match_cnt_o(s_match), .err_cnt_o(s_err)
  );

  commit_scoreboard #(.STOP_ON_ERR(1'b0)) u_cont (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .dut_valid_i(dut_valid), .dut_pc_i(dut_cur.pc), .dut_we_i(dut_cur.we),
    .dut_rd_i(dut_cur.rd), .dut_wdata_i(dut_cur.wd),
    .ref_valid_i(ref_valid), .ref_ready_o(c_ready), .ref_pc_i(ref_cur.pc),
    .ref_we_i(ref_cur.we), .ref_rd_i(ref_cur.rd), .ref_wdata_i(ref_cur.wd),
    .busy_o(c_busy), .done_o(c_done), .pass_o(c_pass), .err_kind_o(c_kind),
    .err_index_o(c_idx), .match_cnt_o(c_match), .err_cnt_o(c_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_clean();
    for (int i = 0; i < N; i++) begin
      dut_r[i].pc = 32'h100 + 32'(4 * i);
      dut_r[i].we = 1'b1;
      dut_r[i].rd = 5'((i % 31) + 1);
      dut_r[i].wd = 32'hA000 + 32'(i);
      ref_r[i]    = dut_r[i];
    end
  endtask

  task automatic do_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Ref record c offered in cycle c; DUT record c committed in cycle c+lead.
  // start is pulsed again in cycle start_at to show it is ignored in RUN.
  task automatic run_stream(input int lead, input int start_at, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      ref_valid = (c < N);
      if (c < N) ref_cur = ref_r[c];
      dut_valid = (c >= lead) && (c - lead < N);
      if (dut_valid) dut_cur = dut_r[c - lead];
      start = (c == start_at);
    end
    @(negedge clk);
    ref_valid = 1'b0;
    dut_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!(s_done && c_done) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("run_ends", 32'(s_done && c_done), 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_busy", 32'(s_busy), 0);
    check("rst_done", 32'(s_done), 0);
    check("rst_ready", 32'(s_ready), 0);
    check("rst_cnt", {s_match, s_err}, 0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(s_ready), 0);

    // Clean run, ref 4 ahead, stray start mid-run
    fill_clean();
    do_start();
    check("run_busy", 32'(s_busy), 1);
    check("run_ready", 32'(s_ready), 1);
    run_stream(4, 10, N + 4);
    wait_done(20);
    check("clean_pass", 32'(s_pass), 1);
    check("clean_match", 32'(s_match), 25);
    check("clean_err", 32'(s_err), 0);
    check("clean_kind", 32'(s_kind), 0);
    check("clean_busy", 32'(s_busy), 0);
    check("clean_cont_pass", 32'(c_pass), 1);

    // r0 write and non-writing record ignore data/rd; data error at 7, PC at 12
    fill_clean();
    dut_r[3].rd = 5'd0;  ref_r[3].rd = 5'd0;  dut_r[3].wd = 32'hDEAD;
    dut_r[5].we = 1'b0;  ref_r[5].we = 1'b0;  dut_r[5].rd = 5'd9;  dut_r[5].wd = 32'h1;
    dut_r[7].rd = 5'd3;  ref_r[7].rd = 5'd3;  dut_r[7].wd = 32'd5; ref_r[7].wd = 32'd6;
    dut_r[12].pc = 32'h7FC;
    do_start();
    run_stream(4, -1, N + 4);
    wait_done(20);
    check("stop_kind", 32'(s_kind), 3);
    check("stop_idx", 32'(s_idx), 7);
    check("stop_match", 32'(s_match), 7);
    check("stop_err", 32'(s_err), 1);
    check("stop_pass", 32'(s_pass), 0);
    check("cont_err", 32'(c_err), 2);
    check("cont_match", 32'(c_match), 23);
    check("cont_kind", 32'(c_kind), 3);
    check("cont_idx", 32'(c_idx), 7);
    check("cont_pass", 32'(c_pass), 0);

    // rd mismatch beats data mismatch; we mismatch on the final compare
    fill_clean();
    dut_r[2].rd = 5'd4;  dut_r[2].wd = 32'hBEEF;
    dut_r[24].we = 1'b0;
    do_start();
    run_stream(4, -1, N + 4);
    wait_done(20);
    check("dest_kind", 32'(s_kind), 2);
    check("dest_idx", 32'(s_idx), 2);
    check("dest_match", 32'(s_match), 2);
    check("last_cont_err", 32'(c_err), 2);
    check("last_cont_match", 32'(c_match), 23);
    check("last_cont_done", 32'(c_done), 1);
    check("last_cont_pass", 32'(c_pass), 0);

    // Overflow: ref idle, 9 DUT commits into a depth-8 FIFO
    do_start();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 8) check("ovf_8_busy", 32'(s_busy), 1);
      dut_valid = 1'b1;
      dut_cur   = '{pc: 32'h900 + 32'(4 * i), we: 1'b1, rd: 5'd1, wd: 32'(i)};
    end
    @(negedge clk);
    dut_valid = 1'b0;
    check("ovf_done", 32'(s_done), 1);
    check("ovf_kind", 32'(s_kind), 4);
    check("ovf_cont_kind", 32'(c_kind), 4);

    // Restart after overflow must flush the stale DUT entries
    fill_clean();
    do_start();
    run_stream(4, -1, N + 4);
    wait_done(20);
    check("flush_pass", 32'(s_pass), 1);
    check("flush_match", 32'(s_match), 25);

    // Timeout: nothing arrives for 64 RUN cycles
    do_start();
    repeat (63) @(negedge clk);
    check("tmo_63_busy", 32'(s_busy), 1);
    @(negedge clk);
    check("tmo_done", 32'(s_done), 1);
    check("tmo_kind", 32'(s_kind), 5);
    check("tmo_pass", 32'(s_pass), 0);

    // Reset mid-run: mismatch on record 0 so u_cont carries state
    fill_clean();
    dut_r[0].wd = 32'h55;
    do_start();
    run_stream(4, -1, 10);
    check("mid_busy", 32'(c_busy), 1);
    check("mid_err", 32'(c_err), 1);
    check("mid_ready", 32'(c_ready), 1);
    #2 rst = 1'b1;
    #1;
    check("mrst_busy", 32'(c_busy), 0);
    check("mrst_ready", 32'(c_ready), 0);
    check("mrst_kind", 32'(c_kind), 0);
    check("mrst_cnt", {c_match, c_err}, 0);
    check("mrst_idx", 32'(c_idx), 0);
    check("mrst_stop_done", 32'({s_done, s_pass}), 0);
    @(negedge clk) rst = 1'b0;

    // Clean restart after reset
    fill_clean();
    do_start();
    run_stream(4, -1, N + 4);
    wait_done(20);
    check("rerun_pass", 32'(s_pass), 1);
    check("rerun_match", 32'(c_match), 25);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/commit_scoreboard.md
# commit_scoreboard

- Synthesizable in-order commit checker for the single-cycle CPU verification environment.
- Compares each instruction retired by the CPU against a golden-model record stream, stored in two parametrised FIFOs.
- Counts matches and mismatches, latches the first mismatch, and detects overflow and stall (timeout).
- Sits beside `Simple_Single_CPU` in the bench, or on FPGA, so checking no longer depends on a behavioural loop.

## Interface
Parameters:
- DATA_W, 32, register write-data width
- ADDR_W, 32, PC width
- REG_W, 5, register index width
- DEPTH, 8, entries per FIFO; power of two, ≥2
- END_COUNT, 25, compares needed to finish a run
- TIMEOUT, 64, max cycles in RUN without a compare
- STOP_ON_ERR, 1, 1 = first mismatch ends the run; 0 = keep counting

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset; **one clock; reset is asynchronous and active-high**
- start_i  in  1  begin a run (pulse)
- dut_valid_i  in  1  DUT commit strobe; not back-pressured
- dut_pc_i  in  ADDR_W  PC of the committed instruction
- dut_we_i  in  1  register write enable
- dut_rd_i  in  REG_W  destination register
- dut_wdata_i  in  DATA_W  write data
- ref_valid_i  in  1  golden record valid
- ref_ready_o  out  1  golden record accepted
- ref_pc_i, ref_we_i, ref_rd_i, ref_wdata_i  in  as DUT fields  golden record
- busy_o  out  1  state is RUN
- done_o  out  1  state is DONE or FAIL
- pass_o  out  1  DONE with err_cnt_o == 0
- err_kind_o  out  3  first error: 0 none, 1 PC, 2 DEST, 3 DATA, 4 OVERFLOW, 5 TIMEOUT
- err_index_o  out  16  compare index (0-based) of the first error
- match_cnt_o, err_cnt_o  out  16  compare counters

## Operation
- States: IDLE, RUN, DONE, FAIL.
- IDLE or DONE or FAIL, start_i=1 → RUN:
  - flush both FIFOs;
  - clear the counters, err_kind_o, err_index_o and the timeout counter.
- start_i in RUN is ignored.
- DUT FIFO:
  - pushed on every dut_valid_i in RUN;
  - a push while full with no pop in the same cycle → err_kind 4, FAIL, regardless of STOP_ON_ERR;
  - push and pop in the same cycle while full is legal.
- Ref FIFO:
  - ref_ready_o = (state == RUN) && !ref_full;
  - a transfer occurs on ref_valid_i && ref_ready_o.
- Compare:
  - happens when both FIFOs are non-empty; both heads are popped on that edge.
  - Priority: PC mismatch (1) > we/rd mismatch (2) > data mismatch (3).
  - rd is checked only when we=1.
  - Data is checked only when we=1 and rd≠0; writes to r0 are don't-care.
- Each compare increments match_cnt_o or err_cnt_o.
  - First error: latch err_kind_o and err_index_o = match_cnt_o + err_cnt_o (before increment).
  - Later errors update only err_cnt_o.
- STOP_ON_ERR=1: any mismatch → FAIL.
- Completion: when total compares reaches END_COUNT → DONE.
  - If a mismatch and the final compare coincide, FAIL wins when STOP_ON_ERR=1.
  - When STOP_ON_ERR=0 the result is DONE with pass_o=0.
- Timeout counter:
  - increments every RUN cycle without a compare;
  - resets on each compare;
  - reaching TIMEOUT → err_kind 5, FAIL.
- In DONE/FAIL, FIFOs are frozen and inputs are ignored.
- Counters saturate at 16'hFFFF.

## Timing
- Reset (asynchronous, immediate) clears everything:
  - state = IDLE; FIFOs empty;
  - all outputs 0, ref_ready_o = 0.
- Reset mid-run discards all state; no partial result survives.
- Counters, err_* and the state update on the compare edge and are visible the next cycle.
- Compare latency: ≥1 cycle after a record's push edge.
- A record pushed at edge N can be compared at edge N+1 at the earliest.
- busy_o/done_o/pass_o are registered state decodes.
- ref_ready_o is combinational from registered state and FIFO level.
- FIFO pointers are REG-wide modulo DEPTH with an extra wrap bit for full/empty.

## Structure
- Package `scb_pkg` holds:
  - the state enum;
  - err_kind codes ERR_NONE..ERR_TIMEOUT;
  - the COUNT_W=16 constant.
- Sub-module `scb_fifo`:
  - parameters WIDTH and DEPTH; ports push, pop, flush, full, empty, head;
  - instantiated twice, once for DUT and once for ref.
  - Record width = ADDR_W + 1 + REG_W + DATA_W.

## Test plan
- 25 identical records, ref preloaded 4 ahead → DONE at compare 25; match_cnt_o=25, pass_o=1, err_kind_o=0.
- Record 7 with DUT wdata=5 vs ref 6, rd=3, STOP_ON_ERR=1 → FAIL next cycle; err_kind_o=3, err_index_o=7, match_cnt_o=7.
- Same stimulus, STOP_ON_ERR=0, plus a PC mismatch at record 12:
  - DONE with err_cnt_o=2, err_kind_o=3, err_index_o=7, pass_o=0.
- Record pair with we=1, rd=0, data differing → counted as a match.
- Ref idle, DUT commits DEPTH+1 records with no pop → FAIL on the 9th push (DEPTH=8), err_kind_o=4.
- ref_valid_i stuck low in RUN → FAIL after 64 cycles, err_kind_o=5.
- rst_i asserted mid-run → all outputs 0 immediately.
- After reset, start_i restarts cleanly.
